// File: rtl/uart_pkg.sv
`default_nettype none
//==============================================================================
// Module   : uart_pkg
// Shared state encoding and default limits for the UART transmit arbiter.
// Revision : 1.0
//==============================================================================
package uart_pkg;

   typedef enum logic [0:0] {
      ST_ARBITRATE = 1'b0,
      ST_GRANTED   = 1'b1
   } arb_state_t;

   localparam int c_max_burst_default    = 16;
   localparam int c_idle_timeout_default = 64;

endpackage
`default_nettype wire

// File: rtl/uart_rr_picker.sv
`default_nettype none
//==============================================================================
// Module   : uart_rr_picker
// Combinational round-robin search: first set request at or above i_ptr, wrapping.
// Revision : 1.0
//==============================================================================
module uart_rr_picker #(
   parameter  int NUM_REQUESTERS = 4,
   localparam int IDX_W          = $clog2(NUM_REQUESTERS)
) (
   input  logic [NUM_REQUESTERS-1:0] i_req,
   input  logic [IDX_W-1:0]          i_ptr,
   output logic                      o_found,
   output logic [IDX_W-1:0]          o_idx
);

   logic [IDX_W:0]   w_sum;
   logic [IDX_W-1:0] w_cand;

   // The extra sum bit keeps ptr + offset exact before the modulo fold.
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      w_sum   = '0;
      w_cand  = '0;
      for (int k = 0; k < NUM_REQUESTERS; k++) begin
         w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
         if (w_sum >= (IDX_W+1)'(NUM_REQUESTERS)) begin
            w_sum = w_sum - (IDX_W+1)'(NUM_REQUESTERS);
         end
         w_cand = w_sum[IDX_W-1:0];
         if (!o_found && i_req[w_cand]) begin
            o_found = 1'b1;
            o_idx   = w_cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : uart_tx_arbiter
// Round-robin arbiter sharing one UART transmitter among several byte sources.
// Revision : 1.0
//==============================================================================
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int NUM_REQUESTERS = 4,
   parameter  int MAX_BURST      = c_max_burst_default,
   parameter  int IDLE_TIMEOUT   = c_idle_timeout_default,
   localparam int IDX_W          = $clog2(NUM_REQUESTERS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQUESTERS*8-1:0] req_data,
   input  logic [NUM_REQUESTERS-1:0]   req_valid,
   input  logic [NUM_REQUESTERS-1:0]   req_last,
   output logic [NUM_REQUESTERS-1:0]   req_ready,
   output logic [7:0]                  tx_data,
   output logic                        tx_valid,
   input  logic                        tx_ready,
   output logic                        grant_valid,
   output logic [IDX_W-1:0]            grant_id
);

   localparam logic [7:0]       c_MAX_BURST    = 8'(MAX_BURST);
   localparam logic [9:0]       c_IDLE_TIMEOUT = 10'(IDLE_TIMEOUT);
   localparam logic [IDX_W-1:0] c_LAST_ID      = IDX_W'(NUM_REQUESTERS - 1);

   arb_state_t       r_state;
   logic [IDX_W-1:0] r_rr_ptr;
   logic [IDX_W-1:0] r_grant_id;
   logic [7:0]       r_burst_cnt;
   logic [9:0]       r_idle_cnt;

   logic             w_found;
   logic [IDX_W-1:0] w_pick;
   logic             w_granted;
   logic             w_sel_valid;
   logic             w_sel_last;
   logic [7:0]       w_sel_data;
   logic             w_handshake;
   logic [7:0]       w_burst_inc;
   logic [9:0]       w_idle_inc;
   logic [IDX_W-1:0] w_next_ptr;

   uart_rr_picker #(
      .NUM_REQUESTERS (NUM_REQUESTERS)
   ) u_picker (
      .i_req   (req_valid),
      .i_ptr   (r_rr_ptr),
      .o_found (w_found),
      .o_idx   (w_pick)
   );

   assign w_granted   = (r_state == ST_GRANTED);
   assign w_sel_valid = req_valid[r_grant_id];
   assign w_sel_last  = req_last[r_grant_id];
   assign w_sel_data  = req_data[{r_grant_id, 3'b000} +: 8];
   assign w_handshake = w_granted && w_sel_valid && tx_ready;
   assign w_burst_inc = r_burst_cnt + 8'd1;
   assign w_idle_inc  = r_idle_cnt + 10'd1;
   assign w_next_ptr  = (r_grant_id == c_LAST_ID) ? '0 : r_grant_id + 1'b1;

   always_comb begin
      req_ready   = '0;
      grant_valid = w_granted;
      tx_valid    = w_granted && w_sel_valid;
      tx_data     = w_granted ? w_sel_data : 8'h00;
      grant_id    = r_grant_id;
      if (w_granted) begin
         req_ready[r_grant_id] = tx_ready;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_ARBITRATE;
         r_rr_ptr    <= '0;
         r_grant_id  <= '0;
         r_burst_cnt <= '0;
         r_idle_cnt  <= '0;
      end else begin
         case (r_state)
            ST_ARBITRATE: begin
               if (w_found) begin
                  r_grant_id  <= w_pick;
                  r_burst_cnt <= '0;
                  r_idle_cnt  <= '0;
                  r_state     <= ST_GRANTED;
               end
            end
            ST_GRANTED: begin
               if (w_handshake) begin
                  r_burst_cnt <= w_burst_inc;
                  r_idle_cnt  <= '0;
                  if (w_sel_last || (w_burst_inc == c_MAX_BURST)) begin
                     r_rr_ptr <= w_next_ptr;
                     r_state  <= ST_ARBITRATE;
                  end
               end else if (!w_sel_valid) begin
                  // A stalled tx_ready with valid high is not idleness.
                  r_idle_cnt <= w_idle_inc;
                  if (w_idle_inc == c_IDLE_TIMEOUT) begin
                     r_rr_ptr <= w_next_ptr;
                     r_state  <= ST_ARBITRATE;
                  end
               end
            end
            default: r_state <= ST_ARBITRATE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_uart_tx_arbiter
// Directed and randomized checks of uart_tx_arbiter against a cycle model.
// Revision : 1.0
//==============================================================================
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int MB = 16;
   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] req_data  = '0;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_last  = '0;
   logic [3:0]  req_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        grant_valid;
   logic [1:0]  grant_id;

   int total = 0;
   int bad   = 0;

   // Model: owner = -1 while arbitrating.
   int m_owner, m_ptr, m_gid, m_burst, m_idle;
   int acc [N];
   logic       obs_gv;
   logic [1:0] obs_gid;
   logic [7:0] obs_data;

   uart_tx_arbiter #(
      .NUM_REQUESTERS (N),
      .MAX_BURST      (MB),
      .IDLE_TIMEOUT   (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_data    (req_data),
      .req_valid   (req_valid),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_release();
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
   endtask

   task automatic step(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                       input logic rdy);
      logic       e_gv, e_txv;
      logic [7:0] e_data;
      logic [3:0] e_rdy;
      bit         found;
      @(negedge clk);
      req_valid = v;
      req_last  = l;
      req_data  = d;
      tx_ready  = rdy;
      #1;
      if (m_owner >= 0) begin
         e_gv   = 1'b1;
         e_txv  = v[m_owner];
         e_data = d[m_owner*8 +: 8];
         e_rdy  = 4'(rdy) << m_owner;
      end else begin
         e_gv   = 1'b0;
         e_txv  = 1'b0;
         e_data = 8'h00;
         e_rdy  = 4'h0;
      end
      chk("grant_valid", grant_valid, e_gv);
      chk("grant_id",    grant_id,    m_gid);
      chk("tx_valid",    tx_valid,    e_txv);
      chk("tx_data",     tx_data,     e_data);
      chk("req_ready",   req_ready,   e_rdy);
      obs_gv   = grant_valid;
      obs_gid  = grant_id;
      obs_data = tx_data;
      for (int i = 0; i < N; i++) begin
         if (req_valid[i] && req_ready[i]) acc[i]++;
      end
      // Advance the model across the coming edge.
      if (m_owner < 0) begin
         found = 0;
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (!found && v[c]) begin
               found   = 1;
               m_owner = c;
               m_gid   = c;
               m_burst = 0;
               m_idle  = 0;
            end
         end
      end else if (v[m_owner] && rdy) begin
         m_burst++;
         m_idle = 0;
         if (l[m_owner] || m_burst == MB) model_release();
      end else if (!v[m_owner]) begin
         m_idle++;
         if (m_idle == TO) model_release();
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      tx_ready  = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_grant_valid", grant_valid, 1'b0);
      chk("rst_tx_valid",    tx_valid,    1'b0);
      chk("rst_req_ready",   req_ready,   4'h0);
      chk("rst_tx_data",     tx_data,     8'h00);
      chk("rst_grant_id",    grant_id,    2'd0);
      @(negedge clk);
      rst     = 1'b0;
      m_owner = -1;
      m_ptr   = 0;
      m_gid   = 0;
      m_burst = 0;
      m_idle  = 0;
      for (int i = 0; i < N; i++) acc[i] = 0;
   endtask

   initial begin
      int         cnt, sw_at, q_len;
      bit         resumed, found3;
      int         probs [N];
      int         order [$];
      logic [3:0] v, l;

      do_reset();

      // Requester 2 sends 0x41..0x43, then requester 3 must win next.
      step(4'b0100, 4'b0000, 32'h0000_0000, 1'b1);
      step(4'b0100, 4'b0000, 32'h0041_0000, 1'b1);
      chk("req2_byte0", obs_data, 8'h41);
      step(4'b0100, 4'b0000, 32'h0042_0000, 1'b1);
      chk("req2_byte1", obs_data, 8'h42);
      step(4'b0100, 4'b0100, 32'h0043_0000, 1'b1);
      chk("req2_byte2", obs_data, 8'h43);
      step(4'b1101, 4'b1101, 32'hA3A2_A1A0, 1'b1);
      chk("req2_released", obs_gv, 1'b0);
      step(4'b1101, 4'b1101, 32'hA3A2_A1A0, 1'b1);
      chk("rr_after_req2", obs_gid, 2'd3);

      // All four requesters with 1-byte messages: fair rotation.
      do_reset();
      order.delete();
      for (int c = 0; c < 12; c++) begin
         step(4'b1111, 4'b1111, 32'h1312_1110 + 32'(c), 1'b1);
         if (obs_gv) order.push_back(int'(obs_gid));
      end
      q_len = order.size();
      chk("rotation_count", q_len, 6);
      for (int i = 0; i < 5 && i < q_len; i++) chk("rotation_order", order[i], i % N);

      // Requester 1 streams without last; burst cap then requester 3, then back to 1.
      do_reset();
      sw_at = -1;
      resumed = 0;
      for (int c = 0; c < 40; c++) begin
         step(4'b1010, 4'b1000, {8'hD3, 8'h00, 8'(c), 8'h00}, 1'b1);
         if (obs_gv && obs_gid == 2'd3 && sw_at < 0) sw_at = acc[1];
         if (obs_gv && obs_gid == 2'd1 && sw_at >= 0) resumed = 1;
      end
      chk("burst_cap", sw_at, MB);
      chk("burst_resume", resumed, 1);

      // Requester 0 goes idle after one byte; grant times out to requester 1.
      do_reset();
      step(4'b0011, 4'b0000, 32'h0000_B1B0, 1'b1);
      step(4'b0011, 4'b0000, 32'h0000_B1B0, 1'b1);
      cnt = 0;
      for (int c = 0; c < 80; c++) begin
         step(4'b0010, 4'b0000, 32'h0000_B100, 1'b1);
         if (obs_gv && obs_gid == 2'd0) cnt++;
         else break;
      end
      chk("idle_cycles", cnt, TO);
      step(4'b0010, 4'b0000, 32'h0000_B100, 1'b1);
      chk("timeout_regrant", {obs_gv, obs_gid}, {1'b1, 2'd1});

      // tx_ready stalled for 100 cycles mid-message.
      do_reset();
      step(4'b0100, 4'b0000, 32'h0055_0000, 1'b0);
      for (int c = 0; c < 100; c++) step(4'b0100, 4'b0000, 32'h0055_0000, 1'b0);
      chk("stall_no_accept", acc[2], 0);
      step(4'b0100, 4'b0100, 32'h0055_0000, 1'b1);
      chk("stall_accept", acc[2], 1);

      // Reset asserted asynchronously while a byte is offered.
      do_reset();
      step(4'b0100, 4'b0000, 32'h0077_0000, 1'b1);
      @(negedge clk);
      req_valid = 4'b0100;
      req_data  = 32'h0077_0000;
      tx_ready  = 1'b1;
      #1;
      chk("pre_rst_tx_valid", tx_valid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_grant_valid", grant_valid, 1'b0);
      chk("async_tx_valid",    tx_valid,    1'b0);
      chk("async_req_ready",   req_ready,   4'h0);
      chk("async_tx_data",     tx_data,     8'h00);
      do_reset();
      step(4'b1010, 4'b0000, 32'h0000_0000, 1'b0);
      step(4'b1010, 4'b0000, 32'h0000_0000, 1'b0);
      chk("rst_regrant", {obs_gv, obs_gid}, {1'b1, 2'd1});

      // Randomized segments with mixed per-requester activity levels.
      do_reset();
      found3 = 0;
      for (int seg = 0; seg < 20; seg++) begin
         for (int i = 0; i < N; i++) begin
            case ($urandom_range(3))
               0:       probs[i] = 0;
               1:       probs[i] = 3;
               2:       probs[i] = 50;
               default: probs[i] = 90;
            endcase
         end
         for (int c = 0; c < 150; c++) begin
            for (int i = 0; i < N; i++) begin
               v[i] = ($urandom_range(99) < probs[i]);
               l[i] = ($urandom_range(3) == 0);
            end
            step(v, l, $urandom, $urandom_range(3) != 0);
            if (obs_gv && obs_gid == 2'd3) found3 = 1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have exactly one clock, clk, and an asynchronous active-high reset, rst, and every register SHALL be cleared when rst is asserted.
REQ-002 Parameter NUM_REQUESTERS, 4, number of byte sources (2..8).
REQ-003 Parameter MAX_BURST, 16, maximum bytes accepted per grant (1..255).
REQ-004 Parameter IDLE_TIMEOUT, 64, clk cycles a granted requester may hold req_valid low before the grant is revoked (1..1023).
REQ-005 clk  input  1  system clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 req_data  input  NUM_REQUESTERS x 8  byte offered by each requester.
REQ-008 req_valid  input  NUM_REQUESTERS  requester has a byte on req_data.
REQ-009 req_last  input  NUM_REQUESTERS  offered byte ends that requester's message.
REQ-010 req_ready  output  NUM_REQUESTERS  byte accepted when req_valid and req_ready are both high at a clk edge.
REQ-011 tx_data  output  8  byte presented to the shared uart_tx.
REQ-012 tx_valid  output  1  tx_data is valid.
REQ-013 tx_ready  input  1  uart_tx accepts tx_data this cycle.
REQ-014 grant_valid  output  1  a requester currently owns the transmitter.
REQ-015 grant_id  output  clog2(NUM_REQUESTERS)  index of the owning requester.

Function
REQ-016 The FSM SHALL have two states: ST_ARBITRATE and ST_GRANTED.
REQ-017 In ST_ARBITRATE the block SHALL drive tx_valid, req_ready and grant_valid low.
REQ-018 In ST_ARBITRATE with any req_valid high, the block SHALL select the first requester with valid high, searching upward from rr_pointer with modulo-NUM_REQUESTERS wrap-around; it SHALL register grant_id, clear burst_count and idle_count, and enter ST_GRANTED on the next edge (one cycle of arbitration latency).
REQ-019 In ST_GRANTED the block SHALL drive grant_valid high, tx_data = req_data[grant_id], tx_valid = req_valid[grant_id], req_ready[grant_id] = tx_ready, and all other req_ready low, combinationally with zero latency.
REQ-020 Each handshake SHALL increment the 8-bit burst_count and clear idle_count.
REQ-021 A handshake with req_last[grant_id] high, or one that brings burst_count to MAX_BURST, SHALL return the FSM to ST_ARBITRATE and set rr_pointer = (grant_id + 1) mod NUM_REQUESTERS.
REQ-022 Each ST_GRANTED cycle with req_valid[grant_id] low SHALL increment idle_count; reaching IDLE_TIMEOUT SHALL release the grant and update rr_pointer exactly as in REQ-021.
REQ-023 In ST_GRANTED, changes to non-granted req_valid SHALL have no effect; a requester deasserting req_valid mid-message SHALL keep the grant until the timeout expires.
REQ-024 With a single active requester, back-to-back messages SHALL be separated by exactly one ST_ARBITRATE cycle.
REQ-025 tx_valid SHALL be high only while grant_valid is high, and at most one req_ready bit SHALL be high in any cycle.

Reset
REQ-026 On rst the block SHALL set: state ST_ARBITRATE, rr_pointer 0, grant_id 0, burst_count 0, idle_count 0; outputs grant_valid 0, tx_valid 0, req_ready all 0, tx_data 0.
REQ-027 Asserting rst mid-byte SHALL abandon the grant immediately; that byte is not accepted. After rst deasserts, arbitration SHALL restart from requester 0.

Structure
REQ-028 Package uart_pkg SHALL hold the arb_state_t enum (ST_ARBITRATE, ST_GRANTED) and the default MAX_BURST and IDLE_TIMEOUT constants.
REQ-029 Round-robin selection SHALL be a combinational sub-module, uart_rr_picker (inputs: request vector and pointer; outputs: found and index). It SHALL be the only sub-module.

Verification
REQ-030 Requester 2 sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43) while tx_ready is held high -> tx_data is 0x41, 0x42, 0x43 on consecutive cycles, the grant drops after 0x43, and rr_pointer becomes 3.
REQ-031 All 4 requesters hold 1-byte messages continuously -> grant order is 0, 1, 2, 3, 0 and no requester is served twice before the others.
REQ-032 Requester 1 streams 20 bytes with no last and MAX_BURST=16 -> exactly 16 bytes are accepted, then requester 3 (valid pending) is granted, then requester 1 resumes.
REQ-033 Requester 0 is granted, sends 1 byte, then drops valid; requester 1 is pending -> the grant is released after exactly 64 idle cycles and requester 1 is granted.
REQ-034 tx_ready stalls low for 100 cycles mid-message -> tx_data/tx_valid are held stable, req_ready stays low, and no timeout occurs.
REQ-035 rst is asserted during a granted transfer -> all outputs are 0 in the same cycle, and after release the first grant goes to the lowest-index valid requester.
